alu_issue_ctrl: RTL and testbench
=================================

ALU_ISSUE_CTRL -- requirements
Module: alu_issue_ctrl

Interface
REQ-001 Parameter ENABLE_M, default 1: when 1, RV32M instructions are decoded; when 0, they are illegal.
REQ-002 Parameter MUL_CYCLES, default 4, range 1..15: accept-to-out_valid latency for MUL/MULH/MULHSU/MULHU.
REQ-003 Parameter DIV_CYCLES, default 32, range 1..63: accept-to-out_valid latency for DIV/DIVU/REM/REMU.
REQ-004 Parameter ALU_OP_W, default 5: width of alu_op.
REQ-005 Port clk, input, 1: single clock; all state updates on the rising edge.
REQ-006 Port reset, input, 1: synchronous, active-high reset.
REQ-007 Port in_valid, input, 1: part_of_inst carries an instruction.
REQ-008 Port in_ready, output, 1: the block can accept an instruction this cycle.
REQ-009 Port part_of_inst, input, 32: full instruction word; only bits [31:25], [14:12] and [6:0] are used.
REQ-010 Port flush, input, 1: abort the in-flight instruction.
REQ-011 Port out_valid, output, 1: alu_op, illegal and multi_cycle are valid.
REQ-012 Port out_ready, input, 1: the consumer takes the result this cycle.
REQ-013 Port alu_op, output, ALU_OP_W: registered ALU operation code.
REQ-014 Port illegal, output, 1: the instruction is an undecodable or disabled encoding.
REQ-015 Port multi_cycle, output, 1: the result came from a MUL- or DIV-class op.
REQ-016 Port busy, output, 1: state is not IDLE.

Function
REQ-017 The decoder SHALL map instructions as follows:
- R-type: ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND.
- I-type: ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI, SRAI; for shifts, funct7 selects SRL/SRA.
- Branch: BEQ, BNE, BLT, BGE, BLTU, BGEU.
- LOAD, STORE and JALR map to ALU_ADD.
- JAL, LUI and AUIPC map to ALU_ZERO.
- funct7=0000001 with opcode ARITHMETIC decodes to the 8 M-ops.
REQ-018 Any other encoding SHALL produce alu_op=ALU_ZERO and illegal=1, with single-cycle timing.
REQ-019 A handshake occurs on a cycle with in_valid && in_ready; the output transfer is out_valid && out_ready.
REQ-020 The FSM SHALL have three states: IDLE, EXEC and DONE.
REQ-021 IDLE, single-cycle accept: go to DONE; out_valid=1 on the next cycle (latency 1).
REQ-022 IDLE, MUL accept: go to EXEC with the counter loaded to MUL_CYCLES-1; MUL_CYCLES=1 goes directly to DONE.
REQ-023 IDLE, DIV accept: go to EXEC with the counter loaded to DIV_CYCLES-1; DIV_CYCLES=1 goes directly to DONE.
REQ-024 EXEC: the counter decrements each cycle; at 0, go to DONE, so out_valid rises exactly N cycles after accept.
REQ-025 DONE: out_valid=1 and outputs hold stable until out_ready=1.
REQ-026 in_ready SHALL be 1 in IDLE, 1 in DONE when out_ready=1, and 0 otherwise.
REQ-027 A new accept in DONE while out_ready=1 SHALL follow the IDLE accept rules in the same cycle, giving back-to-back throughput of 1 per cycle for single-cycle ops.
REQ-028 The decode result SHALL be captured into the output registers only at accept; in EXEC, outputs hold the pending op and out_valid=0.
REQ-029 flush=1 SHALL force IDLE and out_valid=0 on the next cycle, and suppress any accept in that cycle (in_ready=0 while flush=1).
REQ-030 flush together with out_ready in DONE: the transfer completes and no new instruction is accepted.
REQ-031 in_valid=0 in IDLE: state is held and outputs are unchanged except out_valid=0.
REQ-032 No output SHALL depend combinationally on part_of_inst.

Reset
REQ-033 reset SHALL take priority over flush and any handshake.
REQ-034 On reset: state=IDLE, counter=0, alu_op=ALU_ZERO, illegal=0, multi_cycle=0, out_valid=0, busy=0.
REQ-035 in_ready SHALL be 0 while reset=1 and 1 on the first cycle after reset deasserts.
REQ-036 Reset asserted mid-EXEC SHALL discard the op; no out_valid follows.

Structure
REQ-037 ALU op codes SHALL be widened to ALU_OP_W bits in the shared alu_opcodes.v definitions file, with new codes for SRA, SLT, SLTU, BLTU, BGEU and the 8 M-ops.
REQ-038 FUNCT7_MULDIV and funct3 constants SHALL be added to the shared opcodes.v definitions file.
REQ-039 Combinational decode SHALL live in one sub-module, alu_op_decode, with outputs alu_op, illegal, is_mul and is_div.
REQ-040 FSM, counter and output registers SHALL live in the alu_issue_ctrl top.
REQ-041 The counter width SHALL be clog2(max(MUL_CYCLES, DIV_CYCLES)).

Verification
REQ-042 0x003100B3 (add) with in_valid=1 and out_ready=1 -> out_valid the next cycle, alu_op=ALU_ADD, multi_cycle=0, illegal=0.
REQ-043 0x023100B3 (mul) with defaults -> busy=1, out_valid exactly 4 cycles after accept, alu_op=ALU_MUL, multi_cycle=1.
REQ-044 0x023140B3 (div) with flush pulsed at cycle 10 -> IDLE the next cycle, out_valid never asserts, in_ready=1 one cycle after the flush cycle.
REQ-045 Three back-to-back add instructions with out_ready=1 -> three consecutive out_valid cycles; with out_ready=0 held for 3 cycles, the first result holds and in_ready=0.
REQ-046 ENABLE_M=0 with 0x023100B3 -> illegal=1, alu_op=ALU_ZERO, latency 1; opcode 0x7F -> illegal=1.
REQ-047 reset asserted for 1 cycle mid-div -> all outputs at reset values the next cycle, in_ready=1 the cycle after.

Source files
------------

// File: rtl/alu_issue_ctrl_pkg.sv
// Shared constants for the ALU issue controller: ALU op codes, RV32 opcode
// and function-field values, and a helper for sizing the latency counter.
package alu_issue_ctrl_pkg;

  // ALU operation codes (5 bits; the top widens them to ALU_OP_W)
  localparam int unsigned ALU_CODE_W = 5;
  localparam logic [4:0] ALU_ZERO   = 5'd0;
  localparam logic [4:0] ALU_ADD    = 5'd1;
  localparam logic [4:0] ALU_SUB    = 5'd2;
  localparam logic [4:0] ALU_SLL    = 5'd3;
  localparam logic [4:0] ALU_SLT    = 5'd4;
  localparam logic [4:0] ALU_SLTU   = 5'd5;
  localparam logic [4:0] ALU_XOR    = 5'd6;
  localparam logic [4:0] ALU_SRL    = 5'd7;
  localparam logic [4:0] ALU_SRA    = 5'd8;
  localparam logic [4:0] ALU_OR     = 5'd9;
  localparam logic [4:0] ALU_AND    = 5'd10;
  localparam logic [4:0] ALU_BEQ    = 5'd11;
  localparam logic [4:0] ALU_BNE    = 5'd12;
  localparam logic [4:0] ALU_BLT    = 5'd13;
  localparam logic [4:0] ALU_BGE    = 5'd14;
  localparam logic [4:0] ALU_BLTU   = 5'd15;
  localparam logic [4:0] ALU_BGEU   = 5'd16;
  localparam logic [4:0] ALU_MUL    = 5'd17;
  localparam logic [4:0] ALU_MULH   = 5'd18;
  localparam logic [4:0] ALU_MULHSU = 5'd19;
  localparam logic [4:0] ALU_MULHU  = 5'd20;
  localparam logic [4:0] ALU_DIV    = 5'd21;
  localparam logic [4:0] ALU_DIVU   = 5'd22;
  localparam logic [4:0] ALU_REM    = 5'd23;
  localparam logic [4:0] ALU_REMU   = 5'd24;

  // Major opcodes
  localparam logic [6:0] OPC_LOAD      = 7'b0000011;
  localparam logic [6:0] OPC_ARITH_IMM = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
  localparam logic [6:0] OPC_STORE     = 7'b0100011;
  localparam logic [6:0] OPC_ARITH     = 7'b0110011;
  localparam logic [6:0] OPC_LUI       = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
  localparam logic [6:0] OPC_JALR      = 7'b1100111;
  localparam logic [6:0] OPC_JAL       = 7'b1101111;

  // funct7 values
  localparam logic [6:0] FUNCT7_BASE   = 7'b0000000;
  localparam logic [6:0] FUNCT7_ALT    = 7'b0100000;
  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  // funct3 values for integer ops
  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  // funct3 values for branches
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  // funct3 values for RV32M
  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  // Counter width: clog2 of the longer latency, never below one bit
  function automatic int cnt_width(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return (m <= 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/alu_issue_ctrl_decode.sv
// Combinational instruction decoder: maps opcode/funct3/funct7 to an ALU op
// code and flags illegal encodings and MUL/DIV-class operations.
module alu_op_decode
  import alu_issue_ctrl_pkg::*;
#(
  parameter bit ENABLE_M = 1'b1,
  parameter int ALU_OP_W = 5
) (
  input  logic [6:0]          funct7,
  input  logic [2:0]          funct3,
  input  logic [6:0]          opcode,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic                illegal,
  output logic                is_mul,
  output logic                is_div
);

  logic [ALU_CODE_W-1:0] code;

  // Decode table; anything not matched is illegal and decodes as ALU_ZERO
  always_comb begin
    code    = ALU_ZERO;
    illegal = 1'b0;
    is_mul  = 1'b0;
    is_div  = 1'b0;
    case (opcode)
      OPC_ARITH: begin
        if (funct7 == FUNCT7_MULDIV) begin
          if (ENABLE_M) begin
            is_mul = ~funct3[2];
            is_div = funct3[2];
            case (funct3)
              F3_MUL:    code = ALU_MUL;
              F3_MULH:   code = ALU_MULH;
              F3_MULHSU: code = ALU_MULHSU;
              F3_MULHU:  code = ALU_MULHU;
              F3_DIV:    code = ALU_DIV;
              F3_DIVU:   code = ALU_DIVU;
              F3_REM:    code = ALU_REM;
              default:   code = ALU_REMU;
            endcase
          end else begin
            illegal = 1'b1;
          end
        end else if (funct7 == FUNCT7_BASE) begin
          case (funct3)
            F3_ADD:  code = ALU_ADD;
            F3_SLL:  code = ALU_SLL;
            F3_SLT:  code = ALU_SLT;
            F3_SLTU: code = ALU_SLTU;
            F3_XOR:  code = ALU_XOR;
            F3_SR:   code = ALU_SRL;
            F3_OR:   code = ALU_OR;
            default: code = ALU_AND;
          endcase
        end else if (funct7 == FUNCT7_ALT && funct3 == F3_ADD) begin
          code = ALU_SUB;
        end else if (funct7 == FUNCT7_ALT && funct3 == F3_SR) begin
          code = ALU_SRA;
        end else begin
          illegal = 1'b1;
        end
      end
      OPC_ARITH_IMM: begin
        case (funct3)
          F3_ADD:  code = ALU_ADD;
          F3_SLT:  code = ALU_SLT;
          F3_SLTU: code = ALU_SLTU;
          F3_XOR:  code = ALU_XOR;
          F3_OR:   code = ALU_OR;
          F3_AND:  code = ALU_AND;
          F3_SLL: begin
            if (funct7 == FUNCT7_BASE) code = ALU_SLL;
            else                       illegal = 1'b1;
          end
          default: begin
            // Shift-right immediates: funct7 picks logical vs arithmetic
            if (funct7 == FUNCT7_BASE)     code = ALU_SRL;
            else if (funct7 == FUNCT7_ALT) code = ALU_SRA;
            else                           illegal = 1'b1;
          end
        endcase
      end
      OPC_BRANCH: begin
        case (funct3)
          F3_BEQ:  code = ALU_BEQ;
          F3_BNE:  code = ALU_BNE;
          F3_BLT:  code = ALU_BLT;
          F3_BGE:  code = ALU_BGE;
          F3_BLTU: code = ALU_BLTU;
          F3_BGEU: code = ALU_BGEU;
          default: illegal = 1'b1;
        endcase
      end
      OPC_LOAD, OPC_STORE, OPC_JALR: code = ALU_ADD;
      OPC_JAL, OPC_LUI, OPC_AUIPC:   code = ALU_ZERO;
      default:                       illegal = 1'b1;
    endcase
  end

  assign alu_op = ALU_OP_W'(code);

endmodule

// File: rtl/alu_issue_ctrl.sv
// ALU issue controller: accepts one instruction at a time, decodes it, and
// presents the registered ALU op after a class-dependent latency
// (1 cycle for single-cycle ops, MUL_CYCLES / DIV_CYCLES for M-ops).
module alu_issue_ctrl
  import alu_issue_ctrl_pkg::*;
#(
  parameter bit ENABLE_M   = 1'b1,
  parameter int MUL_CYCLES = 4,
  parameter int DIV_CYCLES = 32,
  parameter int ALU_OP_W   = 5
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [31:0]         part_of_inst,
  input  logic                flush,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic                illegal,
  output logic                multi_cycle,
  output logic                busy
);

  localparam int CNT_W = cnt_width(MUL_CYCLES, DIV_CYCLES);
  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]          state;
  logic [CNT_W-1:0]    cnt;
  logic [ALU_OP_W-1:0] dec_op;
  logic                dec_illegal;
  logic                dec_mul;
  logic                dec_div;
  logic                accept;
  logic                unused_inst_bits;

  // Register and immediate fields play no part in op selection
  assign unused_inst_bits = ^{part_of_inst[24:15], part_of_inst[11:7]};

  alu_op_decode #(
    .ENABLE_M (ENABLE_M),
    .ALU_OP_W (ALU_OP_W)
  ) u_decode (
    .funct7  (part_of_inst[31:25]),
    .funct3  (part_of_inst[14:12]),
    .opcode  (part_of_inst[6:0]),
    .alu_op  (dec_op),
    .illegal (dec_illegal),
    .is_mul  (dec_mul),
    .is_div  (dec_div)
  );

  // Ready when idle or when the held result leaves this cycle; flush and
  // reset block any accept
  assign in_ready  = !reset && !flush &&
                     ((state == ST_IDLE) || ((state == ST_DONE) && out_ready));
  assign accept    = in_valid && in_ready;
  assign out_valid = (state == ST_DONE);
  assign busy      = (state != ST_IDLE);

  // FSM, latency counter and output registers; decode captured only at accept
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      alu_op      <= ALU_OP_W'(ALU_ZERO);
      illegal     <= 1'b0;
      multi_cycle <= 1'b0;
    end else if (accept) begin
      alu_op      <= dec_op;
      illegal     <= dec_illegal;
      multi_cycle <= dec_mul | dec_div;
      if (dec_mul && (MUL_CYCLES > 1)) begin
        state <= ST_EXEC;
        cnt   <= MUL_LOAD;
      end else if (dec_div && (DIV_CYCLES > 1)) begin
        state <= ST_EXEC;
        cnt   <= DIV_LOAD;
      end else begin
        state <= ST_DONE;
        cnt   <= '0;
      end
    end else if (flush) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        ST_EXEC: begin
          // The counter reaches zero on the same edge that enters DONE, so
          // out_valid rises exactly N cycles after accept
          cnt <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) state <= ST_DONE;
        end
        ST_DONE: begin
          if (out_ready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: three parameterisations driven in lockstep,
// directed scenarios followed by random traffic, every cycle compared
// against a transaction-level reference model built from an instruction
// mask/match table.
`timescale 1ns/1ps
module tb_alu_issue_ctrl;
  import alu_issue_ctrl_pkg::*;

  localparam int NI = 3;

  logic        clk = 1'b0;
  logic        reset, in_valid, flush, out_ready;
  logic [31:0] part_of_inst;
  logic [NI-1:0] in_ready, out_valid, illegal, multi_cycle, busy;
  logic [4:0]  alu_op [NI];

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  alu_issue_ctrl #(.ENABLE_M(1'b1), .MUL_CYCLES(4), .DIV_CYCLES(32), .ALU_OP_W(5)) u_dut0 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready[0]),
    .part_of_inst(part_of_inst), .flush(flush), .out_valid(out_valid[0]),
    .out_ready(out_ready), .alu_op(alu_op[0]), .illegal(illegal[0]),
    .multi_cycle(multi_cycle[0]), .busy(busy[0]));

  alu_issue_ctrl #(.ENABLE_M(1'b0), .MUL_CYCLES(4), .DIV_CYCLES(32), .ALU_OP_W(5)) u_dut1 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready[1]),
    .part_of_inst(part_of_inst), .flush(flush), .out_valid(out_valid[1]),
    .out_ready(out_ready), .alu_op(alu_op[1]), .illegal(illegal[1]),
    .multi_cycle(multi_cycle[1]), .busy(busy[1]));

  alu_issue_ctrl #(.ENABLE_M(1'b1), .MUL_CYCLES(1), .DIV_CYCLES(3), .ALU_OP_W(5)) u_dut2 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready[2]),
    .part_of_inst(part_of_inst), .flush(flush), .out_valid(out_valid[2]),
    .out_ready(out_ready), .alu_op(alu_op[2]), .illegal(illegal[2]),
    .multi_cycle(multi_cycle[2]), .busy(busy[2]));

  // Instruction table: mask/match over the used fields, kind 0=single 1=mul 2=div
  typedef struct packed {
    logic [31:0] mask;
    logic [31:0] match;
    logic [4:0]  op;
    logic [1:0]  kind;
    logic        needs_m;
  } pat_t;
  pat_t pats[$];

  localparam logic [31:0] M_OP = 32'h0000_007F;
  localparam logic [31:0] M_F3 = 32'h0000_707F;
  localparam logic [31:0] M_F7 = 32'hFE00_707F;

  task automatic add_pat(input logic [31:0] mask, input logic [31:0] match,
                         input logic [4:0] op, input logic [1:0] kind, input logic needs_m);
    pat_t p;
    p.mask = mask; p.match = match; p.op = op; p.kind = kind; p.needs_m = needs_m;
    pats.push_back(p);
  endtask

  task automatic build_table();
    add_pat(M_F7, 32'h0000_0033, ALU_ADD, 0, 0);  add_pat(M_F7, 32'h4000_0033, ALU_SUB, 0, 0);
    add_pat(M_F7, 32'h0000_1033, ALU_SLL, 0, 0);  add_pat(M_F7, 32'h0000_2033, ALU_SLT, 0, 0);
    add_pat(M_F7, 32'h0000_3033, ALU_SLTU, 0, 0); add_pat(M_F7, 32'h0000_4033, ALU_XOR, 0, 0);
    add_pat(M_F7, 32'h0000_5033, ALU_SRL, 0, 0);  add_pat(M_F7, 32'h4000_5033, ALU_SRA, 0, 0);
    add_pat(M_F7, 32'h0000_6033, ALU_OR, 0, 0);   add_pat(M_F7, 32'h0000_7033, ALU_AND, 0, 0);
    add_pat(M_F7, 32'h0200_0033, ALU_MUL, 1, 1);  add_pat(M_F7, 32'h0200_1033, ALU_MULH, 1, 1);
    add_pat(M_F7, 32'h0200_2033, ALU_MULHSU, 1, 1); add_pat(M_F7, 32'h0200_3033, ALU_MULHU, 1, 1);
    add_pat(M_F7, 32'h0200_4033, ALU_DIV, 2, 1);  add_pat(M_F7, 32'h0200_5033, ALU_DIVU, 2, 1);
    add_pat(M_F7, 32'h0200_6033, ALU_REM, 2, 1);  add_pat(M_F7, 32'h0200_7033, ALU_REMU, 2, 1);
    add_pat(M_F3, 32'h0000_0013, ALU_ADD, 0, 0);  add_pat(M_F3, 32'h0000_2013, ALU_SLT, 0, 0);
    add_pat(M_F3, 32'h0000_3013, ALU_SLTU, 0, 0); add_pat(M_F3, 32'h0000_4013, ALU_XOR, 0, 0);
    add_pat(M_F3, 32'h0000_6013, ALU_OR, 0, 0);   add_pat(M_F3, 32'h0000_7013, ALU_AND, 0, 0);
    add_pat(M_F7, 32'h0000_1013, ALU_SLL, 0, 0);  add_pat(M_F7, 32'h0000_5013, ALU_SRL, 0, 0);
    add_pat(M_F7, 32'h4000_5013, ALU_SRA, 0, 0);
    add_pat(M_F3, 32'h0000_0063, ALU_BEQ, 0, 0);  add_pat(M_F3, 32'h0000_1063, ALU_BNE, 0, 0);
    add_pat(M_F3, 32'h0000_4063, ALU_BLT, 0, 0);  add_pat(M_F3, 32'h0000_5063, ALU_BGE, 0, 0);
    add_pat(M_F3, 32'h0000_6063, ALU_BLTU, 0, 0); add_pat(M_F3, 32'h0000_7063, ALU_BGEU, 0, 0);
    add_pat(M_OP, 32'h0000_0003, ALU_ADD, 0, 0);  add_pat(M_OP, 32'h0000_0023, ALU_ADD, 0, 0);
    add_pat(M_OP, 32'h0000_0067, ALU_ADD, 0, 0);  add_pat(M_OP, 32'h0000_006F, ALU_ZERO, 0, 0);
    add_pat(M_OP, 32'h0000_0037, ALU_ZERO, 0, 0); add_pat(M_OP, 32'h0000_0017, ALU_ZERO, 0, 0);
  endtask

  // Reference model: per instance, a pending transaction with its due cycle
  int   mul_n [NI] = '{4, 4, 1};
  int   div_n [NI] = '{32, 32, 3};
  bit   en_m  [NI] = '{1'b1, 1'b0, 1'b1};
  bit   pend  [NI];
  int   due   [NI];
  logic [4:0] m_op  [NI];
  logic m_ill [NI];
  logic m_mc  [NI];
  int   cyc = 0;

  task automatic ref_decode(input logic [31:0] inst, input bit allow_m,
                            output logic [4:0] op, output logic ill, output logic [1:0] kind);
    bit found = 1'b0;
    op = ALU_ZERO; ill = 1'b1; kind = 2'd0;
    foreach (pats[i]) begin
      if (!found && ((inst & pats[i].mask) == pats[i].match) && (!pats[i].needs_m || allow_m)) begin
        found = 1'b1; op = pats[i].op; ill = 1'b0; kind = pats[i].kind;
      end
    end
  endtask

  function automatic bit exp_ov(input int k);
    return pend[k] && (cyc >= due[k]);
  endfunction

  function automatic bit exp_ir(input int k);
    return !reset && !flush && (!pend[k] || (exp_ov(k) && out_ready));
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic check_all();
    for (int k = 0; k < NI; k++) begin
      chk($sformatf("out_valid[%0d]", k),   32'(out_valid[k]),   32'(exp_ov(k)));
      chk($sformatf("in_ready[%0d]", k),    32'(in_ready[k]),    32'(exp_ir(k)));
      chk($sformatf("busy[%0d]", k),        32'(busy[k]),        32'(pend[k]));
      chk($sformatf("alu_op[%0d]", k),      32'(alu_op[k]),      32'(m_op[k]));
      chk($sformatf("illegal[%0d]", k),     32'(illegal[k]),     32'(m_ill[k]));
      chk($sformatf("multi_cycle[%0d]", k), 32'(multi_cycle[k]), 32'(m_mc[k]));
    end
  endtask

  task automatic model_update();
    logic [4:0] op; logic ill; logic [1:0] kind;
    bit ov, acc;
    for (int k = 0; k < NI; k++) begin
      if (reset) begin
        pend[k] = 1'b0; m_op[k] = ALU_ZERO; m_ill[k] = 1'b0; m_mc[k] = 1'b0;
      end else begin
        ov  = exp_ov(k);
        acc = exp_ir(k) && in_valid;
        if (flush || (ov && out_ready)) pend[k] = 1'b0;
        if (acc) begin
          ref_decode(part_of_inst, en_m[k], op, ill, kind);
          pend[k]  = 1'b1;
          due[k]   = cyc + ((kind == 2'd1) ? mul_n[k] : (kind == 2'd2) ? div_n[k] : 1);
          m_op[k]  = op;
          m_ill[k] = ill;
          m_mc[k]  = (kind != 2'd0);
        end
      end
    end
    cyc++;
  endtask

  task automatic step(input logic rs, input logic iv, input logic fl, input logic ordy,
                      input logic [31:0] inst);
    @(negedge clk);
    reset = rs; in_valid = iv; flush = fl; out_ready = ordy; part_of_inst = inst;
    #1;
    check_all();
    @(posedge clk);
    model_update();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b1, 32'h0);
  endtask

  localparam logic [31:0] I_ADD = 32'h003100B3;
  localparam logic [31:0] I_MUL = 32'h023100B3;
  localparam logic [31:0] I_DIV = 32'h023140B3;

  initial begin
    pat_t p;
    logic [31:0] tmp, inst;
    int r;
    build_table();
    for (int k = 0; k < NI; k++) begin
      pend[k] = 1'b0; due[k] = 0; m_op[k] = ALU_ZERO; m_ill[k] = 1'b0; m_mc[k] = 1'b0;
    end
    reset = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0; part_of_inst = '0;
    repeat (2) @(posedge clk);

    step(1'b1, 1'b1, 1'b0, 1'b1, I_ADD);   // reset dominates a would-be accept
    step(1'b0, 1'b0, 1'b0, 1'b1, 32'h0);   // ready right after reset
    step(1'b0, 1'b1, 1'b0, 1'b1, I_ADD);   // add, latency 1
    idle(2);
    step(1'b0, 1'b1, 1'b0, 1'b1, I_MUL);   // mul, latency MUL_CYCLES
    idle(6);
    step(1'b0, 1'b1, 1'b0, 1'b1, I_DIV);   // div, flushed at cycle 10
    idle(9);
    step(1'b0, 1'b0, 1'b1, 1'b1, 32'h0);
    idle(3);
    repeat (3) step(1'b0, 1'b1, 1'b0, 1'b1, I_ADD);  // back-to-back
    idle(1);
    step(1'b0, 1'b1, 1'b0, 1'b0, I_ADD);   // result held under backpressure
    repeat (3) step(1'b0, 1'b1, 1'b0, 1'b0, I_ADD);
    step(1'b0, 1'b1, 1'b0, 1'b1, I_ADD);
    idle(1);
    step(1'b0, 1'b1, 1'b0, 1'b1, 32'h0000007F);  // illegal opcode
    idle(1);
    step(1'b0, 1'b1, 1'b0, 1'b1, I_DIV);   // reset mid-div
    idle(5);
    step(1'b1, 1'b0, 1'b0, 1'b1, 32'h0);
    idle(36);
    step(1'b0, 1'b1, 1'b0, 1'b1, I_ADD);   // flush with out_ready in DONE
    step(1'b0, 1'b1, 1'b1, 1'b1, I_ADD);
    idle(2);

    for (int n = 0; n < 3000; n++) begin
      r = $urandom_range(0, 9);
      if (r < 7) begin
        p = pats[$urandom_range(0, pats.size() - 1)];
        inst = ($urandom & ~p.mask) | p.match;
      end else if (r == 7) begin
        tmp = $urandom;
        inst = {tmp[31:7], 7'h7F};
      end else begin
        inst = $urandom;
      end
      step($urandom_range(0, 199) == 0, $urandom_range(0, 3) != 0,
           $urandom_range(0, 49) == 0, $urandom_range(0, 3) != 0, inst);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
